axis_frame_len_mc: RTL and testbench
====================================

# axis_frame_len_mc

Multi-channel AXI-Stream frame-length monitor. Passively snoops up to CHANNELS independent AXI-Stream interfaces and counts the bytes of each frame, with any tkeep pattern counted by population count. Each completed length goes into a one-deep per-channel slot. A round-robin arbiter then drains the slots onto a single valid/ready length stream tagged with the channel index. The block sits beside MAC/switch datapaths and feeds statistics and rate-accounting logic; it never drives the monitored buses.

## Interface
Parameters:
- DATA_WIDTH, 64, monitored bus data width (sizes KEEP_WIDTH only)
- KEEP_ENABLE, DATA_WIDTH>8, 1: count bytes via tkeep; 0: count beats
- KEEP_WIDTH, DATA_WIDTH/8, tkeep bits per channel
- LEN_WIDTH, 16, length counter and output width
- CHANNELS, 4, number of monitored interfaces, 1..16
- ID_WIDTH, max(1,$clog2(CHANNELS)), derived; not overridden

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- monitor_axis_tkeep  in  CHANNELS*KEEP_WIDTH  channel c at [c*KEEP_WIDTH +: KEEP_WIDTH]
- monitor_axis_tvalid  in  CHANNELS  per-channel valid
- monitor_axis_tready  in  CHANNELS  per-channel ready
- monitor_axis_tlast  in  CHANNELS  per-channel last
- len_tdata  out  LEN_WIDTH  frame length
- len_tid  out  ID_WIDTH  source channel
- len_tuser  out  1  overflow flag (see Configuration)
- len_tvalid  out  1  result valid
- len_tready  in  1  result accept
- frame_active  out  CHANNELS  channel c is mid-frame
- len_drop  out  CHANNELS  one-cycle pulse: result of channel c discarded

## Operation
- A beat is accepted on channel c when tvalid[c] && tready[c]. All other cycles are ignored regardless of tkeep/tlast.
- Beat count: KEEP_ENABLE=1 gives popcount(tkeep[c]), range 0..KEEP_WIDTH, with sparse and zero patterns legal. KEEP_ENABLE=0 gives 1.
- Accumulator acc[c]: each accepted non-last beat adds its count. On an accepted tlast beat, result = acc[c] + count is written to slot[c] and acc[c] is cleared to 0.
- Single-beat frame: tlast on the first beat gives result = count. frame_active[c] is not asserted.
- frame_active[c]: set by an accepted non-last beat, cleared by an accepted tlast beat.
- Slot full when a new result arrives:
  - If the slot is freed in the same cycle, the new result is stored.
  - Otherwise the new result is discarded, the slot keeps its old value, and len_drop[c] pulses for one cycle.
- Output register: loaded from the arbiter winner when empty, or when len_tvalid && len_tready in that cycle. Loading frees that winner's slot.
- Arbiter: round-robin over full slots. After a grant to channel g, the search starts at g+1 mod CHANNELS. After reset the search starts at 0.
- Channels are fully independent; simultaneous tlast on all channels is legal.

## Timing
- An accepted tlast in cycle T sets the slot at edge T.
- With the output register free, len_tvalid is high in cycle T+2.
- len_tdata, len_tid and len_tuser stay stable while len_tvalid && !len_tready.
- Sustained throughput: one result per cycle.
- Reset (asynchronous assert, synchronous deassert assumed upstream) sets all outputs and state to 0:
  - len_tvalid=0, frame_active=0, len_drop=0, len_tdata=0, len_tid=0, len_tuser=0.
  - All accumulators, slots and the arbiter pointer are cleared.
- A frame in progress at reset is lost. The first accepted beat after reset starts a new frame; no partial result is emitted.

## Configuration
- AXIS_FRAME_LEN_SAT_EN defined:
  - The accumulator saturates at 2^LEN_WIDTH-1 and sets a per-channel overflow bit.
  - The overflow bit travels with the result as len_tuser=1 and is cleared with the accumulator.
- AXIS_FRAME_LEN_SAT_EN undefined:
  - Lengths wrap modulo 2^LEN_WIDTH.
  - len_tuser is tied to 0.
  - No overflow state is synthesised.

## Structure
- Package axis_frame_len_pkg holds:
  - the popcount function, parameterised by width;
  - the length-result struct {len, ovf};
  - the ID_WIDTH computation function.
- One sub-module, axis_frame_len_acc, instantiated CHANNELS times. It contains the accumulator, frame_active, slot, drop detection and saturation logic.
- The top level holds the round-robin arbiter, the output register and the mux.

## Test plan
- Channel 0, three beats with tkeep 0xFF, 0xFF, 0x0F (last), len_tready=1 -> len_tdata=20, len_tid=0, len_tuser=0, len_tvalid in cycle T+2.
- Sparse tkeep 0xA5 single-beat frame on channel 2 -> len_tdata=4, len_tid=2; frame_active[2] never asserted.
- Simultaneous single-beat tlast on channels 0..3 (tkeep 0xFF), with len_tready=1 -> four results in consecutive cycles, len_tid order 0,1,2,3. Then repeat with the pointer advanced -> order resumes at the channel after the last grant.
- len_tready=0, two 1-beat frames (lengths 8 then 3) on channel 1 -> slot keeps 8; len_drop[1] pulses once. After release, the output is 8 only.
- LEN_WIDTH=8, 33 beats of tkeep 0xFF on channel 0:
  - with SAT_EN -> len_tdata=255, len_tuser=1;
  - without -> len_tdata=264 mod 256=8, len_tuser=0.
- rst pulsed mid-frame after two beats, then a 1-beat frame with tkeep 0x03 -> len_tdata=2; no stale result.

Source files
------------

// File: rtl/axis_frame_len_pkg.sv
// Shared types and helpers for the multi-channel AXI-Stream frame-length monitor.
package axis_frame_len_pkg;

  localparam int KEEP_MAX = 128;
  localparam int LEN_MAX  = 32;

  typedef struct packed {
    logic [LEN_MAX-1:0] len;
    logic               ovf;
  } len_res_t;

  // Counts set bits among the lowest w bits of v.
  function automatic logic [7:0] popcount(
    input logic [KEEP_MAX-1:0] v,
    input int unsigned         w
  );
    logic [7:0] n;
    n = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i < w) n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

  function automatic int id_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/axis_frame_len_acc.sv
// Per-channel byte accumulator with one-deep result slot and drop detection.
// Saturation is built only when AXIS_FRAME_LEN_SAT_EN is defined.
module axis_frame_len_acc
  import axis_frame_len_pkg::*;
#(
  parameter int KEEP_ENABLE = 1,
  parameter int KEEP_WIDTH  = 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEEP_WIDTH-1:0] keep_i,
  input  logic                  valid_i,
  input  logic                  ready_i,
  input  logic                  last_i,
  input  logic                  take_i,
  output len_res_t              res_o,
  output logic                  full_o,
  output logic                  active_o,
  output logic                  drop_o
);

  logic                 beat;
  logic                 store;
  logic [LEN_WIDTH:0]   cnt;
  logic [LEN_WIDTH:0]   sum;
  logic [LEN_WIDTH-1:0] nxt_len;
  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] slot_q, slot_d;
  logic                 full_q, full_d;
  logic                 active_q, active_d;
  logic                 drop_q, drop_d;

  assign beat  = valid_i & ready_i;
  assign store = beat & last_i & (~full_q | take_i);
  assign cnt   = (KEEP_ENABLE != 0)
               ? (LEN_WIDTH+1)'(popcount(KEEP_MAX'(keep_i), KEEP_WIDTH))
               : (LEN_WIDTH+1)'(1);
  assign sum   = {1'b0, acc_q} + cnt;

`ifdef AXIS_FRAME_LEN_SAT_EN
  logic nxt_ovf;
  logic ovf_q;
  logic slot_ovf_q;

  // Once a frame has overflowed it stays pinned at the maximum.
  assign nxt_ovf = ovf_q | sum[LEN_WIDTH];
  assign nxt_len = nxt_ovf ? '1 : sum[LEN_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      slot_ovf_q <= 1'b0;
    end else if (beat) begin
      ovf_q <= last_i ? 1'b0 : nxt_ovf;
      if (store) slot_ovf_q <= nxt_ovf;
    end
  end

  assign res_o.ovf = slot_ovf_q;
`else
  logic unused_carry;

  assign unused_carry = sum[LEN_WIDTH];
  assign nxt_len      = sum[LEN_WIDTH-1:0];
  assign res_o.ovf    = 1'b0;
`endif

  always_comb begin
    acc_d    = acc_q;
    slot_d   = slot_q;
    active_d = active_q;
    full_d   = full_q & ~take_i;
    drop_d   = beat & last_i & full_q & ~take_i;
    if (beat) begin
      if (last_i) begin
        acc_d    = '0;
        active_d = 1'b0;
      end else begin
        acc_d    = nxt_len;
        active_d = 1'b1;
      end
    end
    if (store) begin
      full_d = 1'b1;
      slot_d = nxt_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      slot_q   <= '0;
      full_q   <= 1'b0;
      active_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      slot_q   <= slot_d;
      full_q   <= full_d;
      active_q <= active_d;
      drop_q   <= drop_d;
    end
  end

  assign res_o.len = LEN_MAX'(slot_q);
  assign full_o    = full_q;
  assign active_o  = active_q;
  assign drop_o    = drop_q;

endmodule

// File: rtl/axis_frame_len_mc.sv
// Multi-channel frame-length monitor: per-channel accumulators, round-robin drain.
// Overflow tagging on len_tuser is built only when AXIS_FRAME_LEN_SAT_EN is defined.
module axis_frame_len_mc
  import axis_frame_len_pkg::*;
#(
  parameter  int DATA_WIDTH  = 64,
  parameter  int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter  int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter  int LEN_WIDTH   = 16,
  parameter  int CHANNELS    = 4,
  localparam int ID_WIDTH    = id_width(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic [CHANNELS-1:0]            monitor_axis_tvalid,
  input  logic [CHANNELS-1:0]            monitor_axis_tready,
  input  logic [CHANNELS-1:0]            monitor_axis_tlast,
  output logic [LEN_WIDTH-1:0]           len_tdata,
  output logic [ID_WIDTH-1:0]            len_tid,
  output logic                           len_tuser,
  output logic                           len_tvalid,
  input  logic                           len_tready,
  output logic [CHANNELS-1:0]            frame_active,
  output logic [CHANNELS-1:0]            len_drop
);

  len_res_t              res [CHANNELS];
  logic [CHANNELS-1:0]   full;
  logic [CHANNELS-1:0]   take;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   win;
  logic [ID_WIDTH:0]     j;
  logic                  found;
  logic                  load;
  logic                  valid_q;
  logic [LEN_WIDTH-1:0]  data_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  unused_res;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    axis_frame_len_acc #(
      .KEEP_ENABLE (KEEP_ENABLE),
      .KEEP_WIDTH  (KEEP_WIDTH),
      .LEN_WIDTH   (LEN_WIDTH)
    ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .keep_i   (monitor_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH]),
      .valid_i  (monitor_axis_tvalid[c]),
      .ready_i  (monitor_axis_tready[c]),
      .last_i   (monitor_axis_tlast[c]),
      .take_i   (take[c]),
      .res_o    (res[c]),
      .full_o   (full[c]),
      .active_o (frame_active[c]),
      .drop_o   (len_drop[c])
    );
  end

  // Search full slots starting at the pointer, wrapping at CHANNELS.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      j = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
      if (j >= (ID_WIDTH+1)'(CHANNELS)) j = j - (ID_WIDTH+1)'(CHANNELS);
      if (!found && full[j[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = j[ID_WIDTH-1:0];
      end
    end
  end

  assign load  = found & (~valid_q | len_tready);
  assign take  = load ? (CHANNELS'(1) << win) : '0;
  assign ptr_d = (win == ID_WIDTH'(CHANNELS-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else if (load) begin
      ptr_q   <= ptr_d;
      valid_q <= 1'b1;
      data_q  <= res[win].len[LEN_WIDTH-1:0];
      id_q    <= win;
    end else if (len_tready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef AXIS_FRAME_LEN_SAT_EN
  logic user_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       user_q <= 1'b0;
    else if (load) user_q <= res[win].ovf;
  end

  assign len_tuser = user_q;
`else
  assign len_tuser = 1'b0;
`endif

  always_comb begin
    unused_res = 1'b0;
    for (int c = 0; c < CHANNELS; c++) unused_res = unused_res ^ (^res[c]);
  end

  assign len_tvalid = valid_q;
  assign len_tdata  = data_q;
  assign len_tid    = id_q;

endmodule

// File: tb/tb_axis_frame_len_mc.sv
// Self-checking bench for axis_frame_len_mc: directed scenarios plus a
// randomized run scored against per-channel expected-length queues.
module tb_axis_frame_len_mc;

  localparam int CH = 4;
  localparam int KW = 8;
  localparam int LW = 8;

`ifdef AXIS_FRAME_LEN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CH*KW-1:0] tkeep;
  logic [CH-1:0]    tvalid;
  logic [CH-1:0]    tready;
  logic [CH-1:0]    tlast;
  logic [LW-1:0]    len_tdata;
  logic [1:0]       len_tid;
  logic             len_tuser;
  logic             len_tvalid;
  logic             len_tready;
  logic [CH-1:0]    frame_active;
  logic [CH-1:0]    len_drop;

  int checks = 0;
  int errors = 0;
  int last_grant = -1;

  always #5 clk = ~clk;

  axis_frame_len_mc #(
    .DATA_WIDTH  (64),
    .KEEP_ENABLE (1),
    .KEEP_WIDTH  (KW),
    .LEN_WIDTH   (LW),
    .CHANNELS    (CH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .monitor_axis_tkeep  (tkeep),
    .monitor_axis_tvalid (tvalid),
    .monitor_axis_tready (tready),
    .monitor_axis_tlast  (tlast),
    .len_tdata           (len_tdata),
    .len_tid             (len_tid),
    .len_tuser           (len_tuser),
    .len_tvalid          (len_tvalid),
    .len_tready          (len_tready),
    .frame_active        (frame_active),
    .len_drop            (len_drop)
  );

  function automatic int exp_len(input int s);
    if (SAT) return (s > 255) ? 255 : s;
    return s % 256;
  endfunction

  function automatic bit exp_ovf(input int s);
    return SAT && (s > 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tvalid = '0;
    tready = '0;
    tlast  = '0;
    tkeep  = '0;
  endtask

  task automatic beat(input int c, input logic [7:0] k, input bit l);
    idle();
    tvalid[c]          = 1'b1;
    tready[c]          = 1'b1;
    tlast[c]           = l;
    tkeep[c*KW +: KW]  = k;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    len_tready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks += 6;
    if (len_tvalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", len_tvalid); end
    if (len_tdata !== '0) begin errors++; $display("FAIL rst_data got %0d want 0", len_tdata); end
    if (len_tid !== '0) begin errors++; $display("FAIL rst_tid got %0d want 0", len_tid); end
    if (len_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser got %b want 0", len_tuser); end
    if (frame_active !== '0) begin errors++; $display("FAIL rst_active got %b want 0", frame_active); end
    if (len_drop !== '0) begin errors++; $display("FAIL rst_drop got %b want 0", len_drop); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_simul();
    int st;
    st = (last_grant + 1) % CH;
    len_tready = 1'b1;
    tvalid = '1;
    tready = '1;
    tlast  = '1;
    tkeep  = '1;
    tick();
    idle();
    tick();
    for (int i = 0; i < CH; i++) begin
      checks += 3;
      if (len_tvalid !== 1'b1) begin errors++; $display("FAIL simul_valid[%0d] got %b want 1", i, len_tvalid); end
      if (int'(len_tid) !== (st + i) % CH) begin
        errors++; $display("FAIL simul_tid[%0d] got %0d want %0d", i, len_tid, (st + i) % CH);
      end
      if (len_tdata !== 8'd8) begin errors++; $display("FAIL simul_data[%0d] got %0d want 8", i, len_tdata); end
      tick();
    end
    checks++;
    if (len_tvalid !== 1'b0) begin errors++; $display("FAIL simul_end got %b want 0", len_tvalid); end
    last_grant = (st + CH - 1) % CH;
  endtask

  task automatic test_advance();
    len_tready = 1'b1;
    beat(1, 8'h01, 1'b1);
    tick();
    checks += 2;
    if (len_tvalid !== 1'b1) begin errors++; $display("FAIL adv_valid got %b want 1", len_tvalid); end
    if (len_tid !== 2'd1) begin errors++; $display("FAIL adv_tid got %0d want 1", len_tid); end
    tick();
    last_grant = 1;
  endtask

  task automatic test_basic();
    len_tready = 1'b1;
    beat(0, 8'hFF, 1'b0);
    checks++;
    if (frame_active[0] !== 1'b1) begin errors++; $display("FAIL basic_active got %b want 1", frame_active[0]); end
    beat(0, 8'hFF, 1'b0);
    beat(0, 8'h0F, 1'b1);
    checks += 2;
    if (len_tvalid !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", len_tvalid); end
    if (frame_active[0] !== 1'b0) begin errors++; $display("FAIL basic_inactive got %b want 0", frame_active[0]); end
    tick();
    checks += 4;
    if (len_tvalid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", len_tvalid); end
    if (len_tdata !== 8'd20) begin errors++; $display("FAIL basic_data got %0d want 20", len_tdata); end
    if (len_tid !== 2'd0) begin errors++; $display("FAIL basic_tid got %0d want 0", len_tid); end
    if (len_tuser !== 1'b0) begin errors++; $display("FAIL basic_tuser got %b want 0", len_tuser); end
    tick();
    last_grant = 0;
  endtask

  task automatic test_sparse();
    len_tready = 1'b1;
    beat(2, 8'hA5, 1'b1);
    checks++;
    if (frame_active[2] !== 1'b0) begin errors++; $display("FAIL sparse_active got %b want 0", frame_active[2]); end
    tick();
    checks += 4;
    if (frame_active[2] !== 1'b0) begin errors++; $display("FAIL sparse_active2 got %b want 0", frame_active[2]); end
    if (len_tvalid !== 1'b1) begin errors++; $display("FAIL sparse_valid got %b want 1", len_tvalid); end
    if (len_tdata !== 8'd4) begin errors++; $display("FAIL sparse_data got %0d want 4", len_tdata); end
    if (len_tid !== 2'd2) begin errors++; $display("FAIL sparse_tid got %0d want 2", len_tid); end
    tick();
    last_grant = 2;
  endtask

  task automatic test_drop();
    int drops;
    drops = 0;
    len_tready = 1'b0;
    beat(0, 8'h01, 1'b1);
    tick();
    beat(1, 8'hFF, 1'b1);
    if (len_drop[1]) drops++;
    beat(1, 8'h07, 1'b1);
    if (len_drop[1]) drops++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (len_drop[1]) drops++;
      checks += 2;
      if (len_tvalid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, len_tvalid); end
      if (len_tdata !== 8'd1 || len_tid !== 2'd0) begin
        errors++; $display("FAIL stall_hold[%0d] got %0d/%0d want 1/0", i, len_tdata, len_tid);
      end
    end
    checks++;
    if (drops !== 1) begin errors++; $display("FAIL drop_pulses got %0d want 1", drops); end
    len_tready = 1'b1;
    tick();
    checks += 3;
    if (len_tvalid !== 1'b1) begin errors++; $display("FAIL drop_valid got %b want 1", len_tvalid); end
    if (len_tdata !== 8'd8) begin errors++; $display("FAIL drop_kept got %0d want 8", len_tdata); end
    if (len_tid !== 2'd1) begin errors++; $display("FAIL drop_tid got %0d want 1", len_tid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (len_tvalid !== 1'b0) begin errors++; $display("FAIL drop_extra[%0d] got %b want 0", i, len_tvalid); end
    end
    last_grant = 1;
  endtask

  task automatic test_sat();
    len_tready = 1'b1;
    for (int i = 0; i < 32; i++) beat(0, 8'hFF, 1'b0);
    beat(0, 8'hFF, 1'b1);
    tick();
    checks += 3;
    if (len_tvalid !== 1'b1) begin errors++; $display("FAIL sat_valid got %b want 1", len_tvalid); end
    if (int'(len_tdata) !== exp_len(264)) begin
      errors++; $display("FAIL sat_data got %0d want %0d", len_tdata, exp_len(264));
    end
    if (len_tuser !== exp_ovf(264)) begin
      errors++; $display("FAIL sat_tuser got %b want %b", len_tuser, exp_ovf(264));
    end
    tick();
    last_grant = 0;
  endtask

  task automatic test_rst_mid();
    len_tready = 1'b1;
    beat(3, 8'hFF, 1'b0);
    beat(3, 8'hFF, 1'b0);
    checks++;
    if (frame_active[3] !== 1'b1) begin errors++; $display("FAIL mid_active got %b want 1", frame_active[3]); end
    rst = 1'b1;
    #2;
    checks++;
    if (frame_active !== '0) begin errors++; $display("FAIL mid_async got %b want 0", frame_active); end
    tick();
    rst = 1'b0;
    tick();
    beat(3, 8'h03, 1'b1);
    tick();
    checks += 3;
    if (len_tvalid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b want 1", len_tvalid); end
    if (len_tdata !== 8'd2) begin errors++; $display("FAIL mid_data got %0d want 2", len_tdata); end
    if (len_tid !== 2'd3) begin errors++; $display("FAIL mid_tid got %0d want 3", len_tid); end
    tick();
    checks++;
    if (len_tvalid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", len_tvalid); end
    last_grant = 3;
  endtask

  task automatic test_random();
    int sum [CH];
    int nb  [CH];
    int qlen[CH][$];
    bit qovf[CH][$];
    int  el;
    bit  eo;
    bit  v, r, l;
    logic [7:0] k;
    len_tready = 1'b1;
    idle();
    for (int c = 0; c < CH; c++) begin
      sum[c] = 0;
      nb[c]  = 0;
    end
    for (int n = 0; n < 3020; n++) begin
      if (len_tvalid === 1'b1) begin
        checks++;
        if (qlen[int'(len_tid)].size() == 0) begin
          errors++; $display("FAIL rnd_unexpected tid %0d data %0d want none", len_tid, len_tdata);
        end else begin
          el = qlen[int'(len_tid)].pop_front();
          eo = qovf[int'(len_tid)].pop_front();
          if (int'(len_tdata) !== el || len_tuser !== eo) begin
            errors++;
            $display("FAIL rnd_result tid %0d got %0d/%b want %0d/%b", len_tid, len_tdata, len_tuser, el, eo);
          end
        end
      end
      checks++;
      if (len_drop !== '0) begin errors++; $display("FAIL rnd_drop got %b want 0", len_drop); end
      idle();
      if (n < 3000) begin
        for (int c = 0; c < CH; c++) begin
          v = ($urandom_range(0, 3) != 0);
          r = ($urandom_range(0, 3) != 0);
          k = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
          l = (c == 0) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
          if (v && r && nb[c] < 5) l = 1'b0;
          tvalid[c]         = v;
          tready[c]         = r;
          tlast[c]          = l;
          tkeep[c*KW +: KW] = k;
          if (v && r) begin
            sum[c] += $countones(k);
            if (l) begin
              qlen[c].push_back(exp_len(sum[c]));
              qovf[c].push_back(exp_ovf(sum[c]));
              sum[c] = 0;
              nb[c]  = 0;
            end else begin
              nb[c]++;
            end
          end
        end
      end
      tick();
    end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (qlen[c].size() != 0) begin
        errors++; $display("FAIL rnd_missing ch %0d got %0d pending want 0", c, qlen[c].size());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    len_tready = 1'b0;
    test_reset();
    test_simul();
    test_advance();
    test_simul();
    test_basic();
    test_sparse();
    test_drop();
    test_sat();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
